// File: rtl/hub75_pkg.sv
// hub75_pkg: shared widths, dump state and pixel type for the HUB75 receiver.
package hub75_pkg;
    localparam int RGB_W = 3;
    localparam int ROW_W = 4;
    typedef enum logic {IDLE, DUMP} state_t;
    typedef struct packed {
        logic [RGB_W-1:0] top;
        logic [RGB_W-1:0] bot;
    } pix_t;
endpackage

// File: rtl/hub75_rx_if.sv
// hub75_rx_if: valid/ready pixel-write port carrying (row, col, top, bot).
interface hub75_rx_if #(parameter int COLS = 32);
    import hub75_pkg::*;
    logic PIX_VALID;
    logic PIX_READY;
    logic [ROW_W-1:0] PIX_ROW;
    logic [$clog2(COLS)-1:0] PIX_COL;
    logic [RGB_W-1:0] PIX_TOP;
    logic [RGB_W-1:0] PIX_BOT;
    modport master (output PIX_VALID, PIX_ROW, PIX_COL, PIX_TOP, PIX_BOT, input PIX_READY);
    modport slave (input PIX_VALID, PIX_ROW, PIX_COL, PIX_TOP, PIX_BOT, output PIX_READY);
endinterface

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: multi-flop synchronizer with a registered rising-edge pulse.
module hub75_sync_edge #(parameter int STAGES = 2) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic [STAGES-1:0] s;
    logic prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            s <= {s[STAGES-2:0], d};
            prev <= s[STAGES-1];
            rise <= s[STAGES-1] & ~prev;
        end
    end
endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver; rebuilds shifted lines and dumps them
// as (row, col, rgb) pixel writes on LATCH.
module hub75_rx import hub75_pkg::*; #(
    parameter int COLS = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic R0, G0, B0,
    input  logic R1, G1, B1,
    input  logic RA, RB, RC, RD,
    input  logic P_CLK,
    input  logic P_LATCH,
    input  logic P_OE,
    hub75_rx_if.master pix,
    output logic LINE_ERR,
    output logic OVERRUN,
    output logic OE_ACTIVE
);
    localparam int CW = $clog2(COLS + 2);
    localparam int CL = $clog2(COLS);
    // One stage deeper than the edge synchronizers so data lines up with the registered edge pulses.
    logic [SYNC_STAGES:0][10:0] ds;
    logic clk_rise, lat_rise, oe_s;
    logic [ROW_W-1:0] row_s, row;
    pix_t px;
    pix_t [COLS-1:0] sh, sh_nxt, snap;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CL-1:0] col;
    logic valid;
    state_t state;
    assign {oe_s, row_s, px} = ds[SYNC_STAGES];
    hub75_sync_edge #(.STAGES(SYNC_STAGES)) u_clk (.clk(CLK_I), .rst(RST_I), .d(P_CLK), .rise(clk_rise));
    hub75_sync_edge #(.STAGES(SYNC_STAGES)) u_lat (.clk(CLK_I), .rst(RST_I), .d(P_LATCH), .rise(lat_rise));
    always_comb begin
        sh_nxt = clk_rise ? {px, sh[COLS-1:1]} : sh;
        cnt_nxt = (clk_rise && cnt != CW'(COLS + 1)) ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ds <= '0;
            sh <= '0;
            snap <= '0;
            cnt <= '0;
            col <= '0;
            row <= '0;
            valid <= 1'b0;
            state <= IDLE;
            LINE_ERR <= 1'b0;
            OVERRUN <= 1'b0;
            OE_ACTIVE <= 1'b0;
        end else begin
            ds <= {ds[SYNC_STAGES-1:0], {P_OE, RD, RC, RB, RA, R0, G0, B0, R1, G1, B1}};
            sh <= sh_nxt;
            cnt <= cnt_nxt;
            OE_ACTIVE <= ~oe_s;
            LINE_ERR <= 1'b0;
            OVERRUN <= 1'b0;
            if (lat_rise && state == IDLE) begin
                snap <= sh_nxt;
                row <= row_s;
                LINE_ERR <= cnt_nxt != CW'(COLS);
                cnt <= '0;
                col <= '0;
                valid <= 1'b1;
                state <= DUMP;
            end else begin
                OVERRUN <= lat_rise;
                if (valid && pix.PIX_READY) begin
                    col <= col + 1'b1;
                    if (col == CL'(COLS - 1)) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
            end
        end
    end
    assign pix.PIX_VALID = valid;
    assign pix.PIX_ROW = row;
    assign pix.PIX_COL = col;
    assign pix.PIX_TOP = snap[col].top;
    assign pix.PIX_BOT = snap[col].bot;
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed HUB75 line shifts with a scoreboard of expected pixel writes.
module tb_hub75_rx;
    localparam int COLS = 32;
    typedef struct packed {
        logic [3:0] row;
        logic [4:0] col;
        logic [5:0] px;
    } word_t;
    logic clk = 1'b0;
    logic rst;
    logic R0, G0, B0, R1, G1, B1, RA, RB, RC, RD, P_CLK, P_LATCH, P_OE;
    logic line_err, overrun, oe_active;
    word_t q[$];
    word_t held, cur, exp_w;
    logic [5:0] mline [COLS];
    int cnt = 0;
    int errors = 0;
    int checks = 0;
    int xfers = 0;
    int le_n = 0;
    int ov_n = 0;
    int x0;
    bit rand_ready = 1'b0;
    bit held_v = 1'b0;

    hub75_rx_if #(.COLS(COLS)) pix ();
    hub75_rx #(.COLS(COLS), .SYNC_STAGES(2)) dut (
        .CLK_I(clk), .RST_I(rst),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .RA(RA), .RB(RB), .RC(RC), .RD(RD),
        .P_CLK(P_CLK), .P_LATCH(P_LATCH), .P_OE(P_OE),
        .pix(pix),
        .LINE_ERR(line_err), .OVERRUN(overrun), .OE_ACTIVE(oe_active)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pxk(input int k);
        logic [2:0] t;
        t = 3'(k);
        return {t, ~t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic [5:0] p);
        {R0, G0, B0, R1, G1, B1} = p;
        tick(2);
        P_CLK = 1'b1;
        tick(2);
        P_CLK = 1'b0;
        tick(2);
        for (int i = 0; i < COLS - 1; i++) mline[i] = mline[i+1];
        mline[COLS-1] = p;
        cnt++;
    endtask

    task automatic latch(input logic [3:0] r, input bit accept);
        int le0, ov0;
        {RD, RC, RB, RA} = r;
        tick(2);
        le0 = le_n;
        ov0 = ov_n;
        if (accept)
            for (int c = 0; c < COLS; c++) q.push_back({r, 5'(c), mline[c]});
        P_LATCH = 1'b1;
        tick(3);
        P_LATCH = 1'b0;
        tick(4);
        if (accept) begin
            check("line_err", le_n - le0, (cnt != COLS) ? 1 : 0);
            check("no_overrun", ov_n - ov0, 0);
            cnt = 0;
        end else begin
            check("overrun", ov_n - ov0, 1);
            check("overrun_no_line_err", le_n - le0, 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() != 0; i++) tick(1);
        check("drained", q.size(), 0);
        tick(3);
    endtask

    task automatic model_clear();
        for (int i = 0; i < COLS; i++) mline[i] = '0;
        cnt = 0;
        q.delete();
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) pix.PIX_READY = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst) held_v = 1'b0;
        else begin
            cur = {pix.PIX_ROW, pix.PIX_COL, pix.PIX_TOP, pix.PIX_BOT};
            if (line_err) le_n++;
            if (overrun) ov_n++;
            if (held_v) check("hold", 32'({pix.PIX_VALID, cur}), 32'({1'b1, held}));
            held_v = pix.PIX_VALID && !pix.PIX_READY;
            held = cur;
            if (pix.PIX_VALID && pix.PIX_READY) begin
                xfers++;
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_word: got col %0d expected no transfer", pix.PIX_COL);
                end
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    check("pixel", 32'(cur), 32'(exp_w));
                end
            end
        end
    end

    initial begin
        {R0, G0, B0, R1, G1, B1, RA, RB, RC, RD, P_CLK, P_LATCH} = '0;
        P_OE = 1'b1;
        pix.PIX_READY = 1'b0;
        rst = 1'b1;
        model_clear();
        tick(2);
        check("reset_outputs", 32'({pix.PIX_VALID, pix.PIX_ROW, pix.PIX_COL, pix.PIX_TOP, pix.PIX_BOT,
                                    line_err, overrun, oe_active}), 0);
        rst = 1'b0;
        tick(2);
        P_OE = 1'b0;
        tick(6);
        check("oe_active_on", 32'(oe_active), 1);
        P_OE = 1'b1;
        tick(6);
        check("oe_active_off", 32'(oe_active), 0);
        // full line, ready held high
        pix.PIX_READY = 1'b1;
        for (int k = 0; k < COLS; k++) shift(pxk(k));
        latch(4'd5, 1'b1);
        drain();
        // short line after reset: column 0 holds the cleared residue
        rst = 1'b1;
        model_clear();
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int k = 0; k < COLS - 1; k++) shift(pxk(k));
        latch(4'd9, 1'b1);
        drain();
        // long line: oldest two pixels fall off
        for (int k = 0; k < COLS + 2; k++) shift(pxk(k));
        latch(4'd3, 1'b1);
        drain();
        // random back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < COLS; k++) shift(pxk(k + 7));
        latch(4'd12, 1'b1);
        drain();
        rand_ready = 1'b0;
        tick(1);
        // overrun: second latch dropped, third dumps the second line
        pix.PIX_READY = 1'b0;
        for (int k = 0; k < COLS; k++) shift(pxk(k));
        latch(4'd1, 1'b1);
        for (int k = 0; k < COLS; k++) shift(6'(k * 5 + 1));
        latch(4'd2, 1'b0);
        pix.PIX_READY = 1'b1;
        drain();
        latch(4'd4, 1'b1);
        drain();
        // reset in the middle of a dump
        for (int k = 0; k < COLS; k++) shift(pxk(k * 3));
        pix.PIX_READY = 1'b0;
        latch(4'd6, 1'b1);
        x0 = xfers;
        pix.PIX_READY = 1'b1;
        for (int i = 0; i < 200 && xfers - x0 < 10; i++) tick(1);
        check("mid_dump_col", 32'(pix.PIX_COL), 10);
        rst = 1'b1;
        #1;
        check("reset_mid_dump", 32'({pix.PIX_VALID, pix.PIX_ROW, pix.PIX_COL, pix.PIX_TOP, pix.PIX_BOT,
                                     line_err, overrun}), 0);
        model_clear();
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int k = 0; k < COLS; k++) shift(pxk(k + 1));
        latch(4'd7, 1'b1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receives a HUB75 LED-panel stream, acting as the panel end of the interface driven by led_driver.
- Oversamples the serial panel signals on the system clock and rebuilds each shifted line in a shift buffer.
- On LATCH, snapshots the line and emits it as (row, col, rgb) pixel writes over a valid/ready port.
- Used as a synthesizable loopback checker or a frame-capture tap next to led_driver.

Parameters:
- COLS, 32, pixels per line (shift-register length), power of two >= 2.
- SYNC_STAGES, 2, synchronizer depth on every HUB75 input, >= 2.

Ports:
- CLK_I  in  1  system clock; must be >= 4x the HUB75 CLK rate.
- RST_I  in  1  reset, asynchronous, active-high.
- R0,G0,B0  in  1 each  top-half pixel bits.
- R1,G1,B1  in  1 each  bottom-half pixel bits.
- RA,RB,RC,RD  in  1 each  row address; RA is the LSB.
- P_CLK  in  1  HUB75 shift clock; data is sampled on its rising edge.
- P_LATCH  in  1  HUB75 latch; acts on its rising edge.
- P_OE  in  1  HUB75 output enable, active-low.
- PIX_VALID  out  1  pixel word valid.
- PIX_READY  in  1  consumer ready.
- PIX_ROW  out  4  row of the current line.
- PIX_COL  out  $clog2(COLS)  column index.
- PIX_TOP  out  3  {R0,G0,B0} for this column.
- PIX_BOT  out  3  {R1,G1,B1} for this column.
- LINE_ERR  out  1  1-cycle pulse: latch arrived after a shift count other than COLS.
- OVERRUN  out  1  1-cycle pulse: latch arrived while a dump was in progress; that latch is dropped.
- OE_ACTIVE  out  1  synchronized, inverted P_OE.

Behaviour:
- Reset values: all outputs 0; shift buffer, snapshot, shift counter and row register are 0; state is IDLE.
- Synchronization: all 13 HUB75 inputs pass through SYNC_STAGES flops.
- Edge detect: rising edges of P_CLK and P_LATCH are detected on the synchronized signals (current sample 1, previous sample 0).
- Shift on P_CLK rise:
  - entry[i] <= entry[i+1] and entry[COLS-1] <= {top,bot} sampled in the same synchronized cycle.
  - After exactly COLS shifts, the first-shifted pixel sits in column 0.
  - Excess shifts discard the oldest pixels.
  - Shift counter increments and saturates at COLS+1.
- Latch on P_LATCH rise, state IDLE:
  - Copy the shift buffer to the snapshot and capture the row from RA..RD.
  - Enter DUMP; PIX_VALID rises on the next cycle with PIX_COL = 0.
  - If the shift count != COLS, pulse LINE_ERR. The dump still proceeds.
  - Clear the shift counter.
- Latch on P_LATCH rise, state DUMP: pulse OVERRUN; snapshot, row, counter and dump progress are unchanged.
- Simultaneous P_CLK and P_LATCH rise in one cycle:
  - The shift is applied first; the snapshot includes the new pixel.
  - That shift counts toward the COLS check.
  - The counter restarts at 0.
- State machine, IDLE -> DUMP:
  - IDLE -> DUMP on an accepted latch.
  - DUMP -> DUMP while col < COLS-1; col advances only on PIX_VALID & PIX_READY.
  - DUMP -> IDLE on the transfer of col COLS-1; PIX_VALID is 0 on the following cycle.
- Handshake:
  - While PIX_VALID=1 and PIX_READY=0, PIX_ROW/COL/TOP/BOT are held stable.
  - PIX_VALID never drops without a transfer, except on reset.
- Throughput: 1 pixel/cycle with PIX_READY held high; a full dump takes exactly COLS cycles.
- Independence: shifting continues during DUMP and does not disturb the snapshot.
- OE_ACTIVE = ~P_OE_sync; it has no effect on capture.
- Reset mid-dump: PIX_VALID and all outputs go to 0 immediately; the dump is abandoned and not resumed.

Decomposition:
- hub75_pkg: RGB_W=3, ROW_W=4, state enum {IDLE, DUMP}, and a pixel struct {top[2:0], bot[2:0]}.
- Sub-module hub75_sync_edge: SYNC_STAGES synchronizer with registered rising-edge output. Instantiated for P_CLK and P_LATCH; a plain synchronizer covers the data, row and OE inputs.

Test Plan:
1. 32 P_CLK pulses with pixel k = {top=k[2:0], bot=~k[2:0]}, RA..RD=5, then latch, PIX_READY=1 -> 32 consecutive transfers, col 0..31, top=col[2:0], row=5, LINE_ERR=0.
2. After reset, 31 shifts then latch -> LINE_ERR one pulse; col 0 = 0 (residual); col 1..31 = pixels 0..30.
3. 34 shifts then latch -> LINE_ERR pulse; col 0 = pixel 2; col 31 = pixel 33.
4. Run test 1 with PIX_READY randomly low ~50% -> every word held stable while stalled; 32 transfers in order; no duplicates.
5. PIX_READY=0, a first line is latched, then 32 new shifts and a second latch -> OVERRUN pulse; after PIX_READY=1 only the first line's 32 pixels appear; a third latch starts a dump of the second line's data.
6. Assert RST_I at transfer col 10 -> PIX_VALID=0 in the same cycle; all outputs 0; a new line plus latch afterwards dumps from col 0.
